pwm_seq_scheduler: RTL and testbench
====================================

# pwm_seq_scheduler

Sequences the high-speed PWM channel bank: on one configuration command, decoded from a UART packet, it issues start pulses to a masked set of channels in ascending index order. It spaces consecutive starts by a programmable gap and waits for each channel's busy acknowledge. It repeats the whole pass a programmable number of times. It sits between the UART register mapper and the per-channel PWM generators and is the only source of channel start requests, so channels never receive overlapping starts.

## Interface
- NUM_CH, 6, number of PWM channels sequenced
- DLY_W, 16, width of inter-start gap counter
- ACK_TIMEOUT, 1024, max cycles to wait for a channel's busy acknowledge
- sys_clk  in  1  single clock (50 MHz domain)
- sys_rst_n  in  1  asynchronous, active-low reset
- cfg_valid  in  1  one-cycle command strobe
- cfg_mask  in  NUM_CH  channels to start; bit i = channel i
- cfg_delay  in  DLY_W  gap cycles between an acknowledge and the next start
- cfg_repeat  in  8  number of passes; 0 treated as 1
- abort  in  1  level; terminates the sequence
- ch_busy  in  NUM_CH  per-channel busy from the PWM generators
- ch_start  out  NUM_CH  one-hot, one-cycle start pulse
- cur_ch  out  clog2(NUM_CH)  index of channel being serviced
- seq_busy  out  1  sequence in progress
- seq_done  out  1  one-cycle pulse on normal completion
- seq_err  out  1  sticky acknowledge-timeout flag
- cfg_rejected  out  1  one-cycle pulse when cfg_valid arrives while seq_busy=1

## Operation
- Reset: all outputs 0, state IDLE, counters 0.
- States: IDLE, ISSUE, WAIT_ACK, GAP, DRAIN, DONE.
- IDLE: cfg_valid latches mask, delay and repeat (0→1), and clears seq_err. Non-zero mask → ISSUE at the lowest set bit. Zero mask → DONE, with no starts.
- ISSUE: if ch_busy[cur] is 1, hold (resource still in use). Otherwise pulse ch_start[cur] for one cycle and go to WAIT_ACK.
- WAIT_ACK: the ack is ch_busy[cur]=1, sampled from the cycle after ch_start onward. On ack: if another mask bit above cur exists, go to GAP (delay>0) or straight to ISSUE at the next bit (delay=0). If no further bit exists, go to DRAIN.
- GAP: count cfg_delay cycles, then go to ISSUE at the next channel. Also used before a repeat pass.
- DRAIN: wait until (ch_busy & mask)==0. Then, if passes remain, decrement the pass count and go to GAP/ISSUE at the lowest mask bit. Otherwise go to DONE.
- DONE: pulse seq_done for one cycle, then go to IDLE.
- abort=1 in any non-IDLE state: next state IDLE, ch_start forced 0 the same cycle, no seq_done, seq_err unchanged.
- cfg_valid while seq_busy: ignored and cfg_rejected pulsed. A cfg_valid in the same cycle as the DONE pulse is also rejected.
- Simultaneous abort and cfg_valid in IDLE: the command is accepted (abort has no effect in IDLE).

## Timing
- cfg_valid sampled in cycle T → seq_busy=1 and ch_start[first] at T+1, provided that channel is idle.
- Ack sampled in cycle A with delay=d:
  - d>0 → next ch_start at A+d+1.
  - d=0 → next ch_start at A+1.
- DRAIN exits in the cycle after (ch_busy & mask)==0 is sampled. seq_done follows 1 cycle later, and seq_busy drops together with seq_done.
- All outputs are registered; no combinational path from inputs to outputs.
- The gap counter is DLY_W bits and never wraps: a value of all-ones gives 2^DLY_W−1 cycles.
- cur_ch holds its last value in IDLE.

## Configuration
- PWM_SEQ_TIMEOUT_EN defined:
  - A WAIT_ACK counter expires after ACK_TIMEOUT cycles without ack.
  - On expiry: seq_err=1 (sticky until the next accepted command), go directly to IDLE, no seq_done.
- PWM_SEQ_TIMEOUT_EN undefined: WAIT_ACK waits indefinitely, seq_err is tied to 0, and ACK_TIMEOUT is unused.

## Test plan
- Mask 6'b000101, delay 3, repeat 1, with a model that asserts busy 1 cycle after start for 10 cycles → ch_start[0] at T+1, ch_start[2] 4 cycles after ch0's ack, a single seq_done after ch2 drains.
- Mask 6'b111111, delay 0, repeat 2 → 12 start pulses in order 0..5,0..5; cfg_rejected pulses for a cfg_valid injected mid-sequence.
- Mask 0 → seq_done at T+2, no ch_start, seq_busy high for exactly 1 cycle.
- ch_busy[3] held high before the command, with mask 6'b001000 → ISSUE holds; start is issued 1 cycle after busy falls.
- Abort asserted during GAP → IDLE next cycle, no further starts, no seq_done.
- With PWM_SEQ_TIMEOUT_EN and ACK_TIMEOUT=16, ch_busy stuck at 0 → seq_err=1 sixteen cycles after start, back in IDLE; the next command clears seq_err.

Source files
------------

// File: rtl/pwm_seq_scheduler.sv
// Start sequencer for the PWM channel bank: staggers one-hot start pulses over a channel mask, repeating passes.
// Optional acknowledge timeout is enabled by defining PWM_SEQ_TIMEOUT_EN.
module pwm_seq_scheduler #(
  parameter int NUM_CH      = 6,
  parameter int DLY_W       = 16,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                      sys_clk_i,
  input  logic                      sys_rst_n_i,
  input  logic                      cfg_valid_i,
  input  logic [NUM_CH-1:0]         cfg_mask_i,
  input  logic [DLY_W-1:0]          cfg_delay_i,
  input  logic [7:0]                cfg_repeat_i,
  input  logic                      abort_i,
  input  logic [NUM_CH-1:0]         ch_busy_i,
  output logic [NUM_CH-1:0]         ch_start_o,
  output logic [$clog2(NUM_CH)-1:0] cur_ch_o,
  output logic                      seq_busy_o,
  output logic                      seq_done_o,
  output logic                      seq_err_o,
  output logic                      cfg_rejected_o
);

  localparam int CW = $clog2(NUM_CH);
  localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, GAP, DRAIN, DONE} state_e;

  state_e            state_q;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] chStart_q;
  logic [DLY_W-1:0]  delay_q;
  logic [DLY_W-1:0]  gapCnt_q;
  logic [7:0]        passCnt_q;
  logic [CW-1:0]     curCh_q;
  logic              seqBusy_q;
  logic              seqDone_q;
  logic              seqErr_q;
  logic              cfgRej_q;

`ifdef PWM_SEQ_TIMEOUT_EN
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  logic [AW-1:0] ackCnt_q;
`else
  logic unusedAckTimeout;
  assign unusedAckTimeout = ^ACK_TIMEOUT;
`endif

  function automatic logic [CW-1:0] lowestSet(input logic [NUM_CH-1:0] m);
    lowestSet = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) lowestSet = CW'(i);
    end
  endfunction

  logic              accept;
  logic              abortNow;
  logic              ack;
  logic              drained;
  logic              passesLeft;
  logic              hasNext;
  logic [NUM_CH-1:0] aboveMask;
  logic [CW-1:0]     nextCh;
  logic [CW-1:0]     firstCh;
  logic              launchReq;
  logic [CW-1:0]     launchCh;

  always_comb begin
    aboveMask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      aboveMask[i] = mask_q[i] && (i > int'(curCh_q));
    end
  end

  assign hasNext    = |aboveMask;
  assign nextCh     = lowestSet(aboveMask);
  assign firstCh    = lowestSet(mask_q);
  assign accept     = (state_q == IDLE) && cfg_valid_i && !seqDone_q;
  assign abortNow   = (state_q != IDLE) && abort_i;
  // The cycle carrying the start pulse is never taken as the acknowledge.
  assign ack        = ch_busy_i[curCh_q] && !(|chStart_q);
  assign drained    = (ch_busy_i & mask_q) == '0;
  assign passesLeft = passCnt_q > 8'd1;

  // Every path that heads for a channel start funnels through launchReq/launchCh.
  always_comb begin
    launchReq = 1'b0;
    launchCh  = curCh_q;
    if (!abortNow) begin
      case (state_q)
        IDLE: if (accept && (|cfg_mask_i)) begin
          launchReq = 1'b1;
          launchCh  = lowestSet(cfg_mask_i);
        end
        ISSUE: launchReq = 1'b1;
        WAIT_ACK: if (ack && hasNext && (delay_q == '0)) begin
          launchReq = 1'b1;
          launchCh  = nextCh;
        end
        GAP: if (gapCnt_q == DLY_W'(1)) launchReq = 1'b1;
        DRAIN: if (drained && passesLeft && (delay_q == '0)) begin
          launchReq = 1'b1;
          launchCh  = firstCh;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      chStart_q <= '0;
      delay_q   <= '0;
      gapCnt_q  <= '0;
      passCnt_q <= '0;
      curCh_q   <= '0;
      seqBusy_q <= 1'b0;
      seqDone_q <= 1'b0;
      seqErr_q  <= 1'b0;
      cfgRej_q  <= 1'b0;
`ifdef PWM_SEQ_TIMEOUT_EN
      ackCnt_q  <= '0;
`endif
    end else begin
      chStart_q <= '0;
      seqDone_q <= 1'b0;
      cfgRej_q  <= cfg_valid_i && (seqBusy_q || seqDone_q);

      if (accept) begin
        mask_q    <= cfg_mask_i;
        delay_q   <= cfg_delay_i;
        passCnt_q <= (cfg_repeat_i == 8'd0) ? 8'd1 : cfg_repeat_i;
        seqErr_q  <= 1'b0;
        seqBusy_q <= 1'b1;
      end

      if ((state_q == DRAIN) && drained && passesLeft && !abortNow)
        passCnt_q <= passCnt_q - 8'd1;

      if (abortNow) begin
        state_q   <= IDLE;
        seqBusy_q <= 1'b0;
      end else if (launchReq) begin
        curCh_q <= launchCh;
        if (ch_busy_i[launchCh]) begin
          state_q <= ISSUE;
        end else begin
          chStart_q <= ONE_HOT0 << launchCh;
          state_q   <= WAIT_ACK;
`ifdef PWM_SEQ_TIMEOUT_EN
          ackCnt_q  <= '0;
`endif
        end
      end else begin
        case (state_q)
          IDLE: if (accept) state_q <= DONE;
          WAIT_ACK: begin
            if (ack) begin
              if (!hasNext) begin
                state_q <= DRAIN;
              end else begin
                state_q  <= GAP;
                curCh_q  <= nextCh;
                gapCnt_q <= delay_q;
              end
            end
`ifdef PWM_SEQ_TIMEOUT_EN
            else if (ackCnt_q == AW'(ACK_TIMEOUT - 1)) begin
              state_q   <= IDLE;
              seqBusy_q <= 1'b0;
              seqErr_q  <= 1'b1;
            end else begin
              ackCnt_q <= ackCnt_q + AW'(1);
            end
`endif
          end
          GAP: gapCnt_q <= gapCnt_q - DLY_W'(1);
          DRAIN: if (drained) begin
            if (!passesLeft) begin
              state_q <= DONE;
            end else begin
              state_q  <= GAP;
              curCh_q  <= firstCh;
              gapCnt_q <= delay_q;
            end
          end
          DONE: begin
            state_q   <= IDLE;
            seqBusy_q <= 1'b0;
            seqDone_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ch_start_o     = chStart_q;
  assign cur_ch_o       = curCh_q;
  assign seq_busy_o     = seqBusy_q;
  assign seq_done_o     = seqDone_q;
  assign seq_err_o      = seqErr_q;
  assign cfg_rejected_o = cfgRej_q;

endmodule

// File: tb/tb_pwm_seq_scheduler.sv
// Scoreboard bench for pwm_seq_scheduler: a busy model answers every start, and expected
// start/done/reject events are queued with their cycle numbers and matched as they appear.
module tb_pwm_seq_scheduler;

  localparam int NUM_CH      = 6;
  localparam int DLY_W       = 16;
  localparam int ACK_TIMEOUT = 16;
  localparam int BUSY_LEN    = 10;

  typedef struct {
    int ch;
    int cyc;
  } startExp_t;

  logic              clock = 1'b0;
  logic              sysRstN;
  logic              cfgValid;
  logic [NUM_CH-1:0] cfgMask;
  logic [DLY_W-1:0]  cfgDelay;
  logic [7:0]        cfgRepeat;
  logic              abortIn;
  logic [NUM_CH-1:0] chBusy;
  logic [NUM_CH-1:0] chStart;
  logic [2:0]        curCh;
  logic              seqBusy;
  logic              seqDone;
  logic              seqErr;
  logic              cfgRejected;

  logic [NUM_CH-1:0] modelBusy;
  logic [NUM_CH-1:0] busyForce;
  bit                busyEnable;
  int                busyCnt [NUM_CH] = '{default: 0};

  int        cyc = 0;
  int        checkCount = 0;
  int        passCount = 0;
  startExp_t expStart[$];
  int        expDone[$];
  int        expRej[$];
  startExp_t monE;
  int        monC;
  logic [NUM_CH-1:0] monVec;

  pwm_seq_scheduler #(
    .NUM_CH(NUM_CH), .DLY_W(DLY_W), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .sys_clk_i     (clock),
    .sys_rst_n_i   (sysRstN),
    .cfg_valid_i   (cfgValid),
    .cfg_mask_i    (cfgMask),
    .cfg_delay_i   (cfgDelay),
    .cfg_repeat_i  (cfgRepeat),
    .abort_i       (abortIn),
    .ch_busy_i     (chBusy),
    .ch_start_o    (chStart),
    .cur_ch_o      (curCh),
    .seq_busy_o    (seqBusy),
    .seq_done_o    (seqDone),
    .seq_err_o     (seqErr),
    .cfg_rejected_o(cfgRejected)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign chBusy = modelBusy | busyForce;

  // Channel model: busy for BUSY_LEN cycles starting the cycle after its start pulse.
  always @(negedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      modelBusy[i] = (busyCnt[i] > 0);
      if (busyCnt[i] > 0) busyCnt[i]--;
      if (chStart[i] && busyEnable) busyCnt[i] = BUSY_LEN;
    end
  end

  always @(negedge clock) begin
    if (sysRstN === 1'b1) begin
      if (chStart !== '0) begin
        checkCount++;
        if (expStart.size() == 0) begin
          $display("[TB] FAIL start_unexpected: got ch_start=%b at cyc %0d, want none", chStart, cyc);
        end else begin
          monE   = expStart.pop_front();
          monVec = NUM_CH'(1) << monE.ch;
          if (chStart !== monVec || cyc != monE.cyc)
            $display("[TB] FAIL start_seq: got ch_start=%b at cyc %0d, want %b at cyc %0d",
                     chStart, cyc, monVec, monE.cyc);
          else passCount++;
        end
      end
      if (seqDone !== 1'b0) begin
        checkCount++;
        if (expDone.size() == 0) begin
          $display("[TB] FAIL done_unexpected: got seq_done=%b at cyc %0d, want none", seqDone, cyc);
        end else begin
          monC = expDone.pop_front();
          if (seqDone !== 1'b1 || cyc != monC)
            $display("[TB] FAIL done_time: got seq_done=%b at cyc %0d, want 1 at cyc %0d", seqDone, cyc, monC);
          else passCount++;
        end
      end
      if (cfgRejected !== 1'b0) begin
        checkCount++;
        if (expRej.size() == 0) begin
          $display("[TB] FAIL rej_unexpected: got cfg_rejected=%b at cyc %0d, want none", cfgRejected, cyc);
        end else begin
          monC = expRej.pop_front();
          if (cfgRejected !== 1'b1 || cyc != monC)
            $display("[TB] FAIL rej_time: got cfg_rejected=%b at cyc %0d, want 1 at cyc %0d", cfgRejected, cyc, monC);
          else passCount++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic runUntil(input int target);
    while (cyc < target) tick();
  endtask

  task automatic sendCfg(input logic [NUM_CH-1:0] m, input int d, input int r);
    cfgValid  = 1'b1;
    cfgMask   = m;
    cfgDelay  = DLY_W'(d);
    cfgRepeat = 8'(r);
  endtask

  task automatic test_reset();
    sysRstN = 1'b0;
    repeat (3) tick();
    checkCount++;
    if (chStart !== '0) $display("[TB] FAIL reset_start: got %b, want 0", chStart); else passCount++;
    checkCount++;
    if (curCh !== 3'd0) $display("[TB] FAIL reset_cur: got %0d, want 0", curCh); else passCount++;
    checkCount++;
    if (seqBusy !== 1'b0) $display("[TB] FAIL reset_busy: got %b, want 0", seqBusy); else passCount++;
    checkCount++;
    if (seqDone !== 1'b0) $display("[TB] FAIL reset_done: got %b, want 0", seqDone); else passCount++;
    checkCount++;
    if (seqErr !== 1'b0) $display("[TB] FAIL reset_err: got %b, want 0", seqErr); else passCount++;
    checkCount++;
    if (cfgRejected !== 1'b0) $display("[TB] FAIL reset_rej: got %b, want 0", cfgRejected); else passCount++;
    sysRstN = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_spaced_pair();
    int t;
    t = cyc;
    sendCfg(6'b000101, 3, 1);
    expStart.push_back('{ch: 0, cyc: t + 1});
    expStart.push_back('{ch: 2, cyc: t + 6});
    expDone.push_back(t + 19);
    tick();
    cfgValid = 1'b0;
    checkCount++;
    if (seqBusy !== 1'b1) $display("[TB] FAIL pair_busy: got %b, want 1", seqBusy); else passCount++;
    runUntil(t + 19);
    cfgValid = 1'b1;
    expRej.push_back(t + 20);
    tick();
    cfgValid = 1'b0;
    checkCount++;
    if (seqBusy !== 1'b0) $display("[TB] FAIL pair_rej_at_done: got seq_busy=%b, want 0", seqBusy); else passCount++;
    runUntil(t + 26);
    checkCount++;
    if (expStart.size() != 0 || expDone.size() != 0 || expRej.size() != 0)
      $display("[TB] FAIL pair_pending: got %0d/%0d/%0d outstanding, want 0/0/0",
               expStart.size(), expDone.size(), expRej.size());
    else passCount++;
  endtask

  task automatic test_full_repeat();
    int t;
    t = cyc;
    sendCfg(6'b111111, 0, 2);
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < NUM_CH; c++)
        expStart.push_back('{ch: c, cyc: t + 1 + 22 * p + 2 * c});
    expDone.push_back(t + 46);
    tick();
    cfgValid = 1'b0;
    runUntil(t + 6);
    sendCfg(6'b000001, 0, 1);
    expRej.push_back(t + 7);
    tick();
    cfgValid = 1'b0;
    checkCount++;
    if (curCh !== 3'd3) $display("[TB] FAIL full_cur: got %0d, want 3", curCh); else passCount++;
    runUntil(t + 52);
    checkCount++;
    if (expStart.size() != 0 || expDone.size() != 0 || expRej.size() != 0)
      $display("[TB] FAIL full_pending: got %0d/%0d/%0d outstanding, want 0/0/0",
               expStart.size(), expDone.size(), expRej.size());
    else passCount++;
  endtask

  task automatic test_zero_mask();
    int t;
    t = cyc;
    sendCfg(6'b000000, 4, 3);
    expDone.push_back(t + 2);
    tick();
    cfgValid = 1'b0;
    checkCount++;
    if (seqBusy !== 1'b1) $display("[TB] FAIL zero_busy_on: got %b, want 1", seqBusy); else passCount++;
    tick();
    checkCount++;
    if (seqBusy !== 1'b0) $display("[TB] FAIL zero_busy_off: got %b, want 0", seqBusy); else passCount++;
    checkCount++;
    if (curCh !== 3'd5) $display("[TB] FAIL zero_cur_hold: got %0d, want 5", curCh); else passCount++;
    runUntil(t + 8);
    checkCount++;
    if (expStart.size() != 0 || expDone.size() != 0 || expRej.size() != 0)
      $display("[TB] FAIL zero_pending: got %0d/%0d/%0d outstanding, want 0/0/0",
               expStart.size(), expDone.size(), expRej.size());
    else passCount++;
  endtask

  task automatic test_busy_hold();
    int t;
    t = cyc;
    busyForce = 6'b001000;
    sendCfg(6'b001000, 0, 1);
    tick();
    cfgValid = 1'b0;
    checkCount++;
    if (seqBusy !== 1'b1 || curCh !== 3'd3)
      $display("[TB] FAIL hold_state: got busy=%b cur=%0d, want busy=1 cur=3", seqBusy, curCh);
    else passCount++;
    runUntil(t + 4);
    busyForce = '0;
    expStart.push_back('{ch: 3, cyc: t + 5});
    expDone.push_back(t + 18);
    runUntil(t + 24);
    checkCount++;
    if (expStart.size() != 0 || expDone.size() != 0 || expRej.size() != 0)
      $display("[TB] FAIL hold_pending: got %0d/%0d/%0d outstanding, want 0/0/0",
               expStart.size(), expDone.size(), expRej.size());
    else passCount++;
  endtask

  task automatic test_abort();
    int t;
    t = cyc;
    sendCfg(6'b000011, 5, 1);
    expStart.push_back('{ch: 0, cyc: t + 1});
    tick();
    cfgValid = 1'b0;
    runUntil(t + 4);
    abortIn = 1'b1;
    tick();
    abortIn = 1'b0;
    checkCount++;
    if (seqBusy !== 1'b0) $display("[TB] FAIL abort_busy: got %b, want 0", seqBusy); else passCount++;
    runUntil(t + 20);
    checkCount++;
    if (expStart.size() != 0 || expDone.size() != 0 || expRej.size() != 0)
      $display("[TB] FAIL abort_pending: got %0d/%0d/%0d outstanding, want 0/0/0",
               expStart.size(), expDone.size(), expRej.size());
    else passCount++;
    t = cyc;
    sendCfg(6'b000010, 0, 1);
    abortIn = 1'b1;
    expStart.push_back('{ch: 1, cyc: t + 1});
    expDone.push_back(t + 14);
    tick();
    cfgValid = 1'b0;
    abortIn  = 1'b0;
    runUntil(t + 20);
    checkCount++;
    if (expStart.size() != 0 || expDone.size() != 0 || expRej.size() != 0)
      $display("[TB] FAIL abort_idle_cfg: got %0d/%0d/%0d outstanding, want 0/0/0",
               expStart.size(), expDone.size(), expRej.size());
    else passCount++;
    checkCount++;
    if (seqErr !== 1'b0) $display("[TB] FAIL abort_err: got %b, want 0", seqErr); else passCount++;
  endtask

`ifdef PWM_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int t;
    busyEnable = 1'b0;
    t = cyc;
    sendCfg(6'b000001, 0, 1);
    expStart.push_back('{ch: 0, cyc: t + 1});
    tick();
    cfgValid = 1'b0;
    runUntil(t + 16);
    checkCount++;
    if (seqErr !== 1'b0 || seqBusy !== 1'b1)
      $display("[TB] FAIL tmo_early: got err=%b busy=%b, want err=0 busy=1", seqErr, seqBusy);
    else passCount++;
    tick();
    checkCount++;
    if (seqErr !== 1'b1 || seqBusy !== 1'b0)
      $display("[TB] FAIL tmo_expire: got err=%b busy=%b, want err=1 busy=0", seqErr, seqBusy);
    else passCount++;
    busyEnable = 1'b1;
    runUntil(t + 22);
    t = cyc;
    sendCfg(6'b000001, 0, 1);
    expStart.push_back('{ch: 0, cyc: t + 1});
    expDone.push_back(t + 14);
    tick();
    cfgValid = 1'b0;
    checkCount++;
    if (seqErr !== 1'b0) $display("[TB] FAIL tmo_clear: got %b, want 0", seqErr); else passCount++;
    runUntil(t + 20);
    checkCount++;
    if (expStart.size() != 0 || expDone.size() != 0 || expRej.size() != 0)
      $display("[TB] FAIL tmo_pending: got %0d/%0d/%0d outstanding, want 0/0/0",
               expStart.size(), expDone.size(), expRej.size());
    else passCount++;
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by time %0t, want finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sysRstN    = 1'b0;
    cfgValid   = 1'b0;
    cfgMask    = '0;
    cfgDelay   = '0;
    cfgRepeat  = '0;
    abortIn    = 1'b0;
    modelBusy  = '0;
    busyForce  = '0;
    busyEnable = 1'b1;
    test_reset();
    test_spaced_pair();
    test_full_repeat();
    test_zero_mask();
    test_busy_hold();
    test_abort();
`ifdef PWM_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
